data_memory_stage: RTL and testbench
====================================

# data_memory_stage

Memory-access (M) stage of the five-stage RV32I pipeline. It sits directly upstream of the MEM/WB pipeline register. It takes the ALU-computed effective address, store data and funct3 from EX/MEM, and performs byte/half/word stores into an internal word-organised data RAM. It returns sign- or zero-extended load data combinationally as readDataM within the same cycle, and it flags and records misaligned accesses.

## Interface

Parameters:
- DEPTH, 256: number of 32-bit words in the data RAM; power of two.
- ADDR_W, $clog2(DEPTH): word-index width.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: reset, asynchronous, active-high.
- MemWriteM, input, 1: store request this cycle.
- MemReadM, input, 1: load request this cycle.
- funct3M, input, 3: RV32I width/sign code. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUresultM, input, 32: byte address.
- WriteDataM, input, 32: store data, right-aligned.
- readDataM, output, 32: extended load data; combinational.
- misalignM, output, 1: current access misaligned; combinational.
- faultValid, output, 1: sticky registered misalignment flag.
- faultAddr, output, 32: byte address of the first misaligned access since reset.

## Operation

**Addressing**
- Word index = ALUresultM[ADDR_W+1:2].
- Byte lane = ALUresultM[1:0].
- Upper address bits are ignored, so addresses wrap modulo DEPTH*4.

**Misalignment**
- misalignM = (MemReadM | MemWriteM) & (half op with addr[0]=1, or word op with addr[1:0]≠00).
- Byte ops are never misaligned.

**Stores** (MemWriteM=1, misalignM=0, legal funct3):
- SB writes WriteDataM[7:0] to the lane addr[1:0].
- SH writes WriteDataM[15:0] to lanes {addr[1],0} and {addr[1],1}.
- SW writes all 4 lanes.
- Bytes outside the enabled lanes are unchanged.
- A misaligned store or illegal funct3 (011, 110, 111) writes nothing.

**Loads** (MemReadM=1):
- The selected lane(s) of the addressed word are right-aligned.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- readDataM = 0 when MemReadM=0, misalignM=1, or funct3 is illegal.

**Simultaneous MemReadM and MemWriteM**
- The store is performed.
- readDataM reflects pre-store contents.

**Fault capture**
- On a rising edge with misalignM=1 and faultValid=0: faultValid←1 and faultAddr←ALUresultM.
- Later faults do not update faultAddr.
- Only reset clears the fault state.

**Reset**
- All RAM words←0, faultValid←0, faultAddr←0.
- Therefore readDataM=0 and misalignM=0 while request inputs are low.
- A reset asserted mid-store aborts the store; the RAM reads 0 afterward.

## Timing

- Store: RAM updates on the rising edge of clock in the cycle MemWriteM is high.
- Read-during-write: in the store cycle a load of the same word shows old data. The new data is visible from the next cycle.
- Load: zero-cycle combinational path from ALUresultM, funct3M and MemReadM to readDataM. This path must settle within the cycle so the MEM/WB register captures it on the next edge. Load-to-use latency is therefore 1 cycle to W.
- Fault: misalignM is same-cycle. faultValid/faultAddr update on the edge that ends the faulting cycle.
- Reset is asynchronous. Outputs take their reset values immediately, independent of clock.
- There is no stall or handshake; the stage accepts one access per cycle.

## Test plan

1. **Reset and idle:** assert reset with the RAM previously written, deassert, then issue LW from 0x00, 0x3FC and 0x80.
   - readDataM=0x00000000 for each load.
   - faultValid=0 and faultAddr=0.
2. **Word access and extension:**
   - SW 0x8081_F27F @0x10, then LB @0x10 → 0x0000007F, LB @0x11 → 0xFFFFFFF2.
   - LBU @0x11 → 0x000000F2.
   - LH @0x12 → 0xFFFF8081, LHU @0x12 → 0x00008081.
   - LW @0x10 → 0x8081F27F.
3. **Partial stores:**
   - Start with SW 0x11223344 @0x20.
   - SB 0xAB @0x21 → LW @0x20 = 0x1122AB44.
   - SH 0xCDEF @0x22 → LW = 0xCDEFAB44.
4. **Misalignment:** SW 0xDEADBEEF @0x30, then SW 0xFFFFFFFF @0x31.
   - misalignM=1 in the SW @0x31 cycle; LW @0x30 still = 0xDEADBEEF.
   - faultValid=1 and faultAddr=0x31 after the edge.
   - Then LH @0x33 gives misalignM=1, readDataM=0, and faultAddr stays 0x31.
5. **Read-during-write and wrap:**
   - Start with SW 0x1 @0x40.
   - Same cycle MemReadM=1, MemWriteM=1, SW 0x2 @0x40 → readDataM=0x1; next cycle LW @0x40 → 0x2.
   - With DEPTH=256, SW 0x55 @0x440 → LW @0x40 = 0x55.
6. **Illegal funct3:** funct3M=011 with MemWriteM=1 and WriteDataM=0x99 @0x50, after SW 0x7 @0x50.
   - LW @0x50 = 0x7; misalignM=0.
   - A load with funct3M=110 gives readDataM=0.

Source files
------------

// File: rtl/data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_stage
// Brief    : RV32I memory-access stage: byte/half/word stores into a word RAM,
//            combinational extended loads, misalignment detect and capture.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUresultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] readDataM,
    output logic        misalignM,
    output logic        faultValid,
    output logic [31:0] faultAddr
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [31:0]       r_mem [DEPTH];
    logic              r_fault_valid;
    logic [31:0]       r_fault_addr;

    logic [ADDR_W-1:0] w_index;
    logic [1:0]        w_lane;
    logic              w_legal;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_store_en;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_index   = ALUresultM[ADDR_W+1:2];
    assign w_lane    = ALUresultM[1:0];
    assign w_legal   = (funct3M == c_F3_B)  || (funct3M == c_F3_H) ||
                       (funct3M == c_F3_W)  || (funct3M == c_F3_BU) ||
                       (funct3M == c_F3_HU);
    assign w_is_half = w_legal && (funct3M[1:0] == 2'b01);
    assign w_is_word = w_legal && (funct3M[1:0] == 2'b10);

    assign misalignM = (MemReadM || MemWriteM) &&
                       ((w_is_half && w_lane[0]) || (w_is_word && (w_lane != 2'b00)));

    assign w_store_en = MemWriteM && w_legal && !misalignM;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        if (w_is_word) begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM;
        end else if (w_is_half) begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
        end else begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{WriteDataM[7:0]}};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Load path reads the pre-edge contents, so a same-cycle store is not forwarded.
    assign w_word = r_mem[w_index];

    always_comb begin
        case (w_lane)
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    end

    always_comb begin
        readDataM = 32'h0000_0000;
        if (MemReadM && !misalignM) begin
            case (funct3M)
                c_F3_B:  readDataM = {{24{w_byte[7]}}, w_byte};
                c_F3_H:  readDataM = {{16{w_half[15]}}, w_half};
                c_F3_W:  readDataM = w_word;
                c_F3_BU: readDataM = {24'h000000, w_byte};
                c_F3_HU: readDataM = {16'h0000, w_half};
                default: readDataM = 32'h0000_0000;
            endcase
        end
    end

    // Only the first misaligned access since reset is recorded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0000_0000;
        end else if (misalignM && !r_fault_valid) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= ALUresultM;
        end
    end

    assign faultValid = r_fault_valid;
    assign faultAddr  = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_stage
// Brief    : Self-checking bench for data_memory_stage against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_stage;

    localparam int c_DEPTH = 256;
    localparam int c_MEMB  = c_DEPTH * 4;

    logic        clock;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  funct3M;
    logic [31:0] ALUresultM;
    logic [31:0] WriteDataM;
    logic [31:0] readDataM;
    logic        misalignM;
    logic        faultValid;
    logic [31:0] faultAddr;

    data_memory_stage #(.DEPTH(c_DEPTH)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .ALUresultM (ALUresultM),
        .WriteDataM (WriteDataM),
        .readDataM  (readDataM),
        .misalignM  (misalignM),
        .faultValid (faultValid),
        .faultAddr  (faultAddr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  m_mem [c_MEMB];
    logic        m_fv;
    logic [31:0] m_fa;
    logic [31:0] last_rd;
    logic        last_mis;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_MEMB; i++) m_mem[i] = 8'h00;
        m_fv = 1'b0;
        m_fa = 32'h0;
    endtask

    // One access cycle: drive after the falling edge, check combinational outputs,
    // then let the rising edge commit and check the registered fault state.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        legal;
        logic        exp_mis;
        logic [31:0] exp_rd;
        logic [63:0] v;
        int          n;
        int          base;
        legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        n     = legal ? (1 << f3[1:0]) : 1;
        base  = int'(addr % c_MEMB);
        exp_mis = (rd || wr) && legal && ((base % n) != 0);
        v = 64'h0;
        for (int i = 0; i < n; i++) v = v | (64'(m_mem[(base + i) % c_MEMB]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        exp_rd = (rd && legal && !exp_mis) ? v[31:0] : 32'h0;

        @(negedge clock);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUresultM = addr; WriteDataM = wd;
        #1;
        last_rd  = readDataM;
        last_mis = misalignM;
        check("readDataM", readDataM, exp_rd);
        check("misalignM", {31'h0, misalignM}, {31'h0, exp_mis});

        @(posedge clock);
        #1;
        if (wr && legal && !exp_mis) begin
            for (int i = 0; i < n; i++) m_mem[(base + i) % c_MEMB] = wd[8*i +: 8];
        end
        if (exp_mis && !m_fv) begin
            m_fv = 1'b1;
            m_fa = addr;
        end
        check("faultValid", {31'h0, faultValid}, {31'h0, m_fv});
        check("faultAddr", faultAddr, m_fa);
    endtask

    task automatic idle();
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000; ALUresultM = 32'h0; WriteDataM = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        model_clear();
        reset = 1'b1;
        #12;
        check("reset readDataM", readDataM, 32'h0);
        check("reset misalignM", {31'h0, misalignM}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Word access and extension
        access(0, 1, 3'b010, 32'h10, 32'h8081_F27F);
        access(1, 0, 3'b000, 32'h10, 0); check("T2 LB 0x10",  last_rd, 32'h0000_007F);
        access(1, 0, 3'b000, 32'h11, 0); check("T2 LB 0x11",  last_rd, 32'hFFFF_FFF2);
        access(1, 0, 3'b100, 32'h11, 0); check("T2 LBU 0x11", last_rd, 32'h0000_00F2);
        access(1, 0, 3'b001, 32'h12, 0); check("T2 LH 0x12",  last_rd, 32'hFFFF_8081);
        access(1, 0, 3'b101, 32'h12, 0); check("T2 LHU 0x12", last_rd, 32'h0000_8081);
        access(1, 0, 3'b010, 32'h10, 0); check("T2 LW 0x10",  last_rd, 32'h8081_F27F);

        // Partial stores
        access(0, 1, 3'b010, 32'h20, 32'h1122_3344);
        access(0, 1, 3'b000, 32'h21, 32'h0000_00AB);
        access(1, 0, 3'b010, 32'h20, 0); check("T3 after SB", last_rd, 32'h1122_AB44);
        access(0, 1, 3'b001, 32'h22, 32'h0000_CDEF);
        access(1, 0, 3'b010, 32'h20, 0); check("T3 after SH", last_rd, 32'hCDEF_AB44);

        // Misalignment and first-fault capture
        access(0, 1, 3'b010, 32'h30, 32'hDEAD_BEEF);
        access(0, 1, 3'b010, 32'h31, 32'hFFFF_FFFF);
        check("T4 SW mis", {31'h0, last_mis}, 32'h1);
        check("T4 faultValid", {31'h0, faultValid}, 32'h1);
        check("T4 faultAddr", faultAddr, 32'h31);
        access(1, 0, 3'b010, 32'h30, 0); check("T4 LW 0x30", last_rd, 32'hDEAD_BEEF);
        access(1, 0, 3'b001, 32'h33, 0);
        check("T4 LH mis", {31'h0, last_mis}, 32'h1);
        check("T4 LH data", last_rd, 32'h0);
        check("T4 faultAddr kept", faultAddr, 32'h31);

        // Read-during-write and address wrap
        access(0, 1, 3'b010, 32'h40, 32'h1);
        access(1, 1, 3'b010, 32'h40, 32'h2); check("T5 RDW old", last_rd, 32'h1);
        access(1, 0, 3'b010, 32'h40, 0);     check("T5 RDW new", last_rd, 32'h2);
        access(0, 1, 3'b010, 32'h440, 32'h55);
        access(1, 0, 3'b010, 32'h40, 0);     check("T5 wrap", last_rd, 32'h55);

        // Illegal funct3
        access(0, 1, 3'b010, 32'h50, 32'h7);
        access(0, 1, 3'b011, 32'h50, 32'h99);
        check("T6 illegal mis", {31'h0, last_mis}, 32'h0);
        access(1, 0, 3'b010, 32'h50, 0); check("T6 LW 0x50", last_rd, 32'h7);
        access(1, 0, 3'b110, 32'h50, 0); check("T6 load 110", last_rd, 32'h0);

        // Randomized traffic concentrated on a small window to create hits
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0, 10'($urandom_range(0, 127))};
            access(1'($urandom), 1'($urandom), 3'($urandom), a, $urandom);
        end

        // Asynchronous reset with RAM populated
        @(negedge clock);
        MemReadM = 1'b1; funct3M = 3'b010; ALUresultM = 32'h10;
        #2;
        reset = 1'b1;
        #1;
        check("async rst data", readDataM, 32'h0);
        check("async rst fv", {31'h0, faultValid}, 32'h0);
        check("async rst fa", faultAddr, 32'h0);
        idle();
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        access(1, 0, 3'b010, 32'h00, 0);  check("T1 LW 0x00",  last_rd, 32'h0);
        access(1, 0, 3'b010, 32'h3FC, 0); check("T1 LW 0x3FC", last_rd, 32'h0);
        access(1, 0, 3'b010, 32'h80, 0);  check("T1 LW 0x80",  last_rd, 32'h0);

        // Reset during a store cycle aborts the store
        access(0, 1, 3'b010, 32'h60, 32'h1234_5678);
        @(negedge clock);
        MemWriteM = 1'b1; funct3M = 3'b010; ALUresultM = 32'h60; WriteDataM = 32'hAAAA_AAAA;
        #2;
        reset = 1'b1;
        @(negedge clock);
        idle();
        reset = 1'b0;
        model_clear();
        access(1, 0, 3'b010, 32'h60, 0); check("mid-store reset", last_rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
